xpe_writeback: RTL and testbench
================================

XPE_WRITEBACK -- requirements
Module: xpe_writeback

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 12: IO buffer word-address width.
REQ-002 The block SHALL have parameter DATA_WIDTH, default 256: XPE result and IO buffer word width.
REQ-003 The block SHALL have parameter FIFO_DEPTH, default 4: result FIFO entries, power of two.
REQ-004 The block SHALL have port clk, input, 1: the single clock, rising-edge active.
REQ-005 The block SHALL have port rst, input, 1: asynchronous, active-low reset.
REQ-006 The block SHALL have port start, input, 1: one-cycle pulse that launches a write-back job.
REQ-007 The block SHALL have port addr_start_o, input, ADDR_WIDTH: first IO buffer address of the job, sampled on start.
REQ-008 The block SHALL have port out_num, input, ADDR_WIDTH: number of words in the job, sampled on start.
REQ-009 The block SHALL have port xpe_data, input, DATA_WIDTH: XPE result word.
REQ-010 The block SHALL have port xpe_data_valid, input, 1: xpe_data is valid this cycle; there is no backpressure toward the XPE.
REQ-011 The block SHALL have port io_wr_ready, input, 1: the IO buffer can accept a write.
REQ-012 The block SHALL have port io_wr_en, output, 1: IO buffer write strobe.
REQ-013 The block SHALL have port io_wr_addr, output, ADDR_WIDTH: IO buffer write address.
REQ-014 The block SHALL have port io_wr_data, output, DATA_WIDTH: IO buffer write data.
REQ-015 The block SHALL have port wb_busy, output, 1: a job is in progress.
REQ-016 The block SHALL have port wb_done, output, 1: one-cycle pulse marking job completion.
REQ-017 The block SHALL have port wb_err, output, 2: sticky error flags; bit 0 = overflow, bit 1 = stray valid.

Function
REQ-018 The FSM SHALL have three states: IDLE, RUN and DONE.
REQ-019 IDLE -> RUN on start when out_num != 0; IDLE -> DONE on start when out_num == 0; RUN -> DONE on the cycle the last of the out_num writes is issued; DONE -> IDLE unconditionally after one cycle.
REQ-020 start while in RUN or DONE SHALL be ignored.
REQ-021 On an accepted start, the block SHALL latch addr_start_o into the address register, latch out_num into the remaining-word counter, and clear wb_err.
REQ-022 In RUN, any cycle with xpe_data_valid=1 and the FIFO not full SHALL push xpe_data into the FIFO.
REQ-023 If the FIFO is full in RUN, a push SHALL still be accepted when a pop happens in the same cycle.
REQ-024 If the FIFO is full and no pop happens in that cycle, the word SHALL be dropped and wb_err[0] set.
REQ-025 xpe_data_valid in IDLE or DONE SHALL drop the word and set wb_err[1].
REQ-026 Pop condition: state RUN, FIFO not empty, io_wr_ready=1, and remaining count > 0.
REQ-027 A pop SHALL register io_wr_en=1, io_wr_data=FIFO head and io_wr_addr=address register on the next edge.
REQ-028 After a pop, the address register SHALL increase by 1 modulo 2^ADDR_WIDTH, and the remaining count SHALL decrease by 1.
REQ-029 io_wr_en SHALL be high for exactly one cycle per pop; io_wr_addr and io_wr_data SHALL hold their values when io_wr_en=0.
REQ-030 There SHALL be no FIFO bypass: a word that is valid at cycle t SHALL appear with io_wr_en high no earlier than cycle t+2.
REQ-031 The sustained throughput SHALL be one word per cycle while io_wr_ready stays high.
REQ-032 wb_busy SHALL be 1 in RUN and DONE and 0 in IDLE.
REQ-033 wb_done SHALL be 1 exactly in the DONE cycle.
REQ-034 When the job ends, words left in the FIFO in excess of out_num SHALL be flushed on entry to DONE and wb_err[0] set.
REQ-035 FIFO pointers SHALL be log2(FIFO_DEPTH)+1 bits wide; full and empty SHALL be derived from the pointer MSB and the remaining bits, with pointer wrap-around.

Reset
REQ-036 While rst=0, the state SHALL be IDLE, the FIFO empty, the counters and address register 0, io_wr_en=0, io_wr_addr=0, io_wr_data=0, wb_busy=0, wb_done=0 and wb_err=0.
REQ-037 Reset asserted mid-job SHALL abandon the job immediately, with no further writes and no wb_done pulse.
REQ-038 After reset is released, the block SHALL accept start on the first rising edge.

Verification
REQ-039 Scenario: start with addr_start_o=0x100, out_num=3; three consecutive valid words A, B, C; io_wr_ready=1 -> writes A@0x100, B@0x101, C@0x102 on consecutive cycles, the first write 2 cycles after A; wb_done pulses 1 cycle after the C write; wb_err=0.
REQ-040 Scenario: out_num=6, io_wr_ready=0 while 5 words arrive back-to-back, then ready=1 -> the first 4 words are written in order, the 5th is dropped, wb_err=01, and the job stays in RUN awaiting 2 more words.
REQ-041 Scenario: addr_start_o=0xFFE, out_num=4 -> the write addresses are 0xFFE, 0xFFF, 0x000, 0x001.
REQ-042 Scenario: start with out_num=0 -> wb_done pulses on the next cycle, no io_wr_en, wb_busy high for 1 cycle.
REQ-043 Scenario: xpe_data_valid pulsed in IDLE, then a new start -> wb_err=10 after the pulse, cleared to 00 on start, and no write occurs.
REQ-044 Scenario: rst driven low after 2 of 4 writes -> all outputs are 0 within the same cycle; after release, a new job with out_num=1 completes normally.

Source files
------------

// File: rtl/xpe_writeback.sv
// XPE result write-back: buffers XPE result words in a small FIFO and streams
// them to consecutive IO buffer addresses, one word per cycle when the buffer is ready.
module xpe_writeback #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 256,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [ADDR_WIDTH-1:0] addr_start_o,
   input  logic [ADDR_WIDTH-1:0] out_num,
   input  logic [DATA_WIDTH-1:0] xpe_data,
   input  logic                  xpe_data_valid,
   input  logic                  io_wr_ready,
   output logic                  io_wr_en,
   output logic [ADDR_WIDTH-1:0] io_wr_addr,
   output logic [DATA_WIDTH-1:0] io_wr_data,
   output logic                  wb_busy,
   output logic                  wb_done,
   output logic [1:0]            wb_err
);

   localparam int IW = $clog2(FIFO_DEPTH);
   localparam int PW = IW + 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t                state;
   logic [ADDR_WIDTH-1:0] addr_reg;
   logic [ADDR_WIDTH-1:0] remaining;
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   logic [PW-1:0]         wr_next;
   logic [PW-1:0]         rd_next;
   logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];

   logic in_run;
   logic fifo_empty;
   logic fifo_full;
   logic pop;
   logic push;
   logic overflow;
   logic stray;
   logic job_end;
   logic excess;

   // Extra pointer MSB distinguishes a full FIFO from an empty one after wrap.
   always_comb begin
      in_run     = (state == RUN);
      fifo_empty = (wr_ptr == rd_ptr);
      fifo_full  = (wr_ptr[PW-1] != rd_ptr[PW-1]) && (wr_ptr[IW-1:0] == rd_ptr[IW-1:0]);
      pop        = in_run && !fifo_empty && io_wr_ready && (remaining != '0);
      push       = in_run && xpe_data_valid && (!fifo_full || pop);
      overflow   = in_run && xpe_data_valid && fifo_full && !pop;
      stray      = !in_run && xpe_data_valid;
      job_end    = in_run && (remaining == '0);
      wr_next    = wr_ptr + PW'(push);
      rd_next    = rd_ptr + PW'(pop);
      excess     = job_end && (wr_next != rd_ptr);
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr[IW-1:0]] <= xpe_data;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         addr_reg   <= '0;
         remaining  <= '0;
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         io_wr_en   <= 1'b0;
         io_wr_addr <= '0;
         io_wr_data <= '0;
         wb_busy    <= 1'b0;
         wb_done    <= 1'b0;
         wb_err     <= 2'b00;
      end else begin
         io_wr_en <= 1'b0;
         wb_done  <= 1'b0;
         wr_ptr   <= wr_next;
         rd_ptr   <= rd_next;

         if (pop) begin
            io_wr_en   <= 1'b1;
            io_wr_addr <= addr_reg;
            io_wr_data <= mem[rd_ptr[IW-1:0]];
            addr_reg   <= addr_reg + 1'b1;
            remaining  <= remaining - 1'b1;
         end

         if (overflow) begin
            wb_err[0] <= 1'b1;
         end

         case (state)
            IDLE: begin
               if (start) begin
                  addr_reg  <= addr_start_o;
                  remaining <= out_num;
                  wb_err    <= 2'b00;
                  wb_busy   <= 1'b1;
                  if (out_num == '0) begin
                     state   <= DONE;
                     wb_done <= 1'b1;
                  end else begin
                     state <= RUN;
                  end
               end
            end
            RUN: begin
               // Last write already issued: anything still queued is surplus.
               if (job_end) begin
                  state   <= DONE;
                  wb_done <= 1'b1;
                  if (excess) begin
                     rd_ptr    <= wr_next;
                     wb_err[0] <= 1'b1;
                  end
               end
            end
            DONE: begin
               state   <= IDLE;
               wb_busy <= 1'b0;
            end
            default: begin
               state   <= IDLE;
               wb_busy <= 1'b0;
            end
         endcase

         if (stray) begin
            wb_err[1] <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_xpe_writeback.sv
// Directed table-driven bench for xpe_writeback: each row drives one cycle of
// inputs and states the outputs expected just after the following rising edge.
module tb_xpe_writeback;

   localparam int AW = 12;
   localparam int DW = 256;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          start = 1'b0;
   logic [AW-1:0] addr_start_o = '0;
   logic [AW-1:0] out_num = '0;
   logic [DW-1:0] xpe_data = '0;
   logic          xpe_data_valid = 1'b0;
   logic          io_wr_ready = 1'b0;
   logic          io_wr_en;
   logic [AW-1:0] io_wr_addr;
   logic [DW-1:0] io_wr_data;
   logic          wb_busy;
   logic          wb_done;
   logic [1:0]    wb_err;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   xpe_writeback #(
      .ADDR_WIDTH(AW),
      .DATA_WIDTH(DW),
      .FIFO_DEPTH(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .addr_start_o(addr_start_o),
      .out_num(out_num),
      .xpe_data(xpe_data),
      .xpe_data_valid(xpe_data_valid),
      .io_wr_ready(io_wr_ready),
      .io_wr_en(io_wr_en),
      .io_wr_addr(io_wr_addr),
      .io_wr_data(io_wr_data),
      .wb_busy(wb_busy),
      .wb_done(wb_done),
      .wb_err(wb_err)
   );

   typedef struct {
      logic          start;
      logic [AW-1:0] addr;
      logic [AW-1:0] num;
      logic [DW-1:0] data;
      logic          valid;
      logic          ready;
      logic          e_en;
      logic [AW-1:0] e_addr;
      logic [DW-1:0] e_data;
      logic          e_busy;
      logic          e_done;
      logic [1:0]    e_err;
   } vec_t;

   vec_t vecs[$];

   function automatic logic [DW-1:0] dw(input logic [31:0] n);
      return {8{n}};
   endfunction

   function automatic vec_t mk(input logic st, input logic [AW-1:0] a, input logic [AW-1:0] n,
                               input logic [DW-1:0] d, input logic vl, input logic rd,
                               input logic en, input logic [AW-1:0] ea, input logic [DW-1:0] ed,
                               input logic bz, input logic dn, input logic [1:0] er);
      vec_t r;
      r.start = st;  r.addr = a;    r.num = n;     r.data = d;
      r.valid = vl;  r.ready = rd;  r.e_en = en;   r.e_addr = ea;
      r.e_data = ed; r.e_busy = bz; r.e_done = dn; r.e_err = er;
      return r;
   endfunction

   task automatic check_output(input string name, input logic en, input logic [AW-1:0] ea,
                               input logic [DW-1:0] ed, input logic bz, input logic dn,
                               input logic [1:0] er);
      checks++;
      if ({io_wr_en, io_wr_addr, io_wr_data, wb_busy, wb_done, wb_err} !== {en, ea, ed, bz, dn, er}) begin
         errors++;
         $display("[TB] FAIL %s: got en=%0b addr=%h data=%h busy=%0b done=%0b err=%b, want en=%0b addr=%h data=%h busy=%0b done=%0b err=%b",
                  name, io_wr_en, io_wr_addr, io_wr_data, wb_busy, wb_done, wb_err,
                  en, ea, ed, bz, dn, er);
      end
   endtask

   task automatic apply_stimulus(input string name, input vec_t v);
      start          = v.start;
      addr_start_o   = v.addr;
      out_num        = v.num;
      xpe_data       = v.data;
      xpe_data_valid = v.valid;
      io_wr_ready    = v.ready;
      @(posedge clk);
      #1;
      check_output(name, v.e_en, v.e_addr, v.e_data, v.e_busy, v.e_done, v.e_err);
   endtask

   initial begin
      // Three-word job at 0x100; a start arriving in RUN and one in DONE are ignored.
      vecs.push_back(mk(1, 'h100, 3, '0,         0, 1,  0, 'h000, '0,         1, 0, 0));
      vecs.push_back(mk(0, 0,     0, dw('hA1),   1, 1,  0, 'h000, '0,         1, 0, 0));
      vecs.push_back(mk(0, 0,     0, dw('hB1),   1, 1,  1, 'h100, dw('hA1),   1, 0, 0));
      vecs.push_back(mk(1, 'hABC, 7, dw('hC1),   1, 1,  1, 'h101, dw('hB1),   1, 0, 0));
      vecs.push_back(mk(0, 0,     0, '0,         0, 1,  1, 'h102, dw('hC1),   1, 0, 0));
      vecs.push_back(mk(0, 0,     0, '0,         0, 1,  0, 'h102, dw('hC1),   1, 1, 0));
      vecs.push_back(mk(1, 'h123, 2, '0,         0, 1,  0, 'h102, dw('hC1),   0, 0, 0));
      // Zero-length job.
      vecs.push_back(mk(1, 'h055, 0, '0,         0, 1,  0, 'h102, dw('hC1),   1, 1, 0));
      vecs.push_back(mk(0, 0,     0, '0,         0, 1,  0, 'h102, dw('hC1),   0, 0, 0));
      // Stray valid in IDLE, then a start clears the flag.
      vecs.push_back(mk(0, 0,     0, dw('hBAD),  1, 1,  0, 'h102, dw('hC1),   0, 0, 2));
      vecs.push_back(mk(0, 0,     0, '0,         0, 1,  0, 'h102, dw('hC1),   0, 0, 2));
      vecs.push_back(mk(1, 'h200, 1, '0,         0, 1,  0, 'h102, dw('hC1),   1, 0, 0));
      vecs.push_back(mk(0, 0,     0, dw('hD1),   1, 1,  0, 'h102, dw('hC1),   1, 0, 0));
      vecs.push_back(mk(0, 0,     0, '0,         0, 1,  1, 'h200, dw('hD1),   1, 0, 0));
      vecs.push_back(mk(0, 0,     0, '0,         0, 1,  0, 'h200, dw('hD1),   1, 1, 0));
      vecs.push_back(mk(0, 0,     0, '0,         0, 1,  0, 'h200, dw('hD1),   0, 0, 0));
      // Address wrap from 0xFFE.
      vecs.push_back(mk(1, 'hFFE, 4, '0,         0, 1,  0, 'h200, dw('hD1),   1, 0, 0));
      vecs.push_back(mk(0, 0,     0, dw('hE0),   1, 1,  0, 'h200, dw('hD1),   1, 0, 0));
      vecs.push_back(mk(0, 0,     0, dw('hE1),   1, 1,  1, 'hFFE, dw('hE0),   1, 0, 0));
      vecs.push_back(mk(0, 0,     0, dw('hE2),   1, 1,  1, 'hFFF, dw('hE1),   1, 0, 0));
      vecs.push_back(mk(0, 0,     0, dw('hE3),   1, 1,  1, 'h000, dw('hE2),   1, 0, 0));
      vecs.push_back(mk(0, 0,     0, '0,         0, 1,  1, 'h001, dw('hE3),   1, 0, 0));
      vecs.push_back(mk(0, 0,     0, '0,         0, 1,  0, 'h001, dw('hE3),   1, 1, 0));
      vecs.push_back(mk(0, 0,     0, '0,         0, 1,  0, 'h001, dw('hE3),   0, 0, 0));
      // Overflow: five words against a stalled buffer, fifth is lost.
      vecs.push_back(mk(1, 'h300, 6, '0,         0, 0,  0, 'h001, dw('hE3),   1, 0, 0));
      vecs.push_back(mk(0, 0,     0, dw('h50),   1, 0,  0, 'h001, dw('hE3),   1, 0, 0));
      vecs.push_back(mk(0, 0,     0, dw('h51),   1, 0,  0, 'h001, dw('hE3),   1, 0, 0));
      vecs.push_back(mk(0, 0,     0, dw('h52),   1, 0,  0, 'h001, dw('hE3),   1, 0, 0));
      vecs.push_back(mk(0, 0,     0, dw('h53),   1, 0,  0, 'h001, dw('hE3),   1, 0, 0));
      vecs.push_back(mk(0, 0,     0, dw('h54),   1, 0,  0, 'h001, dw('hE3),   1, 0, 1));
      vecs.push_back(mk(0, 0,     0, '0,         0, 1,  1, 'h300, dw('h50),   1, 0, 1));
      vecs.push_back(mk(0, 0,     0, '0,         0, 1,  1, 'h301, dw('h51),   1, 0, 1));
      vecs.push_back(mk(0, 0,     0, '0,         0, 1,  1, 'h302, dw('h52),   1, 0, 1));
      vecs.push_back(mk(0, 0,     0, '0,         0, 1,  1, 'h303, dw('h53),   1, 0, 1));
      vecs.push_back(mk(0, 0,     0, '0,         0, 1,  0, 'h303, dw('h53),   1, 0, 1));
      vecs.push_back(mk(0, 0,     0, '0,         0, 1,  0, 'h303, dw('h53),   1, 0, 1));
      vecs.push_back(mk(0, 0,     0, dw('h55),   1, 1,  0, 'h303, dw('h53),   1, 0, 1));
      vecs.push_back(mk(0, 0,     0, dw('h56),   1, 1,  1, 'h304, dw('h55),   1, 0, 1));
      vecs.push_back(mk(0, 0,     0, '0,         0, 1,  1, 'h305, dw('h56),   1, 0, 1));
      vecs.push_back(mk(0, 0,     0, '0,         0, 1,  0, 'h305, dw('h56),   1, 1, 1));
      vecs.push_back(mk(0, 0,     0, '0,         0, 1,  0, 'h305, dw('h56),   0, 0, 1));
      // Surplus words at job end are flushed and flagged; next job sees an empty FIFO.
      vecs.push_back(mk(1, 'h400, 1, '0,         0, 1,  0, 'h305, dw('h56),   1, 0, 0));
      vecs.push_back(mk(0, 0,     0, dw('h60),   1, 1,  0, 'h305, dw('h56),   1, 0, 0));
      vecs.push_back(mk(0, 0,     0, dw('h61),   1, 1,  1, 'h400, dw('h60),   1, 0, 0));
      vecs.push_back(mk(0, 0,     0, dw('h62),   1, 1,  0, 'h400, dw('h60),   1, 1, 1));
      vecs.push_back(mk(0, 0,     0, '0,         0, 1,  0, 'h400, dw('h60),   0, 0, 1));
      vecs.push_back(mk(1, 'h500, 1, '0,         0, 1,  0, 'h400, dw('h60),   1, 0, 0));
      vecs.push_back(mk(0, 0,     0, '0,         0, 1,  0, 'h400, dw('h60),   1, 0, 0));
      vecs.push_back(mk(0, 0,     0, '0,         0, 1,  0, 'h400, dw('h60),   1, 0, 0));
      vecs.push_back(mk(0, 0,     0, dw('h70),   1, 1,  0, 'h400, dw('h60),   1, 0, 0));
      vecs.push_back(mk(0, 0,     0, '0,         0, 1,  1, 'h500, dw('h70),   1, 0, 0));
      vecs.push_back(mk(0, 0,     0, '0,         0, 1,  0, 'h500, dw('h70),   1, 1, 0));
      vecs.push_back(mk(0, 0,     0, '0,         0, 1,  0, 'h500, dw('h70),   0, 0, 0));
      // Full FIFO accepts a push when a pop happens in the same cycle.
      vecs.push_back(mk(1, 'h600, 5, '0,         0, 0,  0, 'h500, dw('h70),   1, 0, 0));
      vecs.push_back(mk(0, 0,     0, dw('h80),   1, 0,  0, 'h500, dw('h70),   1, 0, 0));
      vecs.push_back(mk(0, 0,     0, dw('h81),   1, 0,  0, 'h500, dw('h70),   1, 0, 0));
      vecs.push_back(mk(0, 0,     0, dw('h82),   1, 0,  0, 'h500, dw('h70),   1, 0, 0));
      vecs.push_back(mk(0, 0,     0, dw('h83),   1, 0,  0, 'h500, dw('h70),   1, 0, 0));
      vecs.push_back(mk(0, 0,     0, dw('h84),   1, 1,  1, 'h600, dw('h80),   1, 0, 0));
      vecs.push_back(mk(0, 0,     0, '0,         0, 1,  1, 'h601, dw('h81),   1, 0, 0));
      vecs.push_back(mk(0, 0,     0, '0,         0, 1,  1, 'h602, dw('h82),   1, 0, 0));
      vecs.push_back(mk(0, 0,     0, '0,         0, 1,  1, 'h603, dw('h83),   1, 0, 0));
      vecs.push_back(mk(0, 0,     0, '0,         0, 1,  1, 'h604, dw('h84),   1, 0, 0));
      vecs.push_back(mk(0, 0,     0, '0,         0, 1,  0, 'h604, dw('h84),   1, 1, 0));
      vecs.push_back(mk(0, 0,     0, '0,         0, 1,  0, 'h604, dw('h84),   0, 0, 0));

      $display("[TB] xpe_writeback directed test");
      repeat (2) @(posedge clk);
      #1;
      check_output("reset_state", 0, '0, '0, 0, 0, 2'b00);
      rst = 1'b1;

      for (int i = 0; i < vecs.size(); i++) begin
         apply_stimulus($sformatf("vec%0d", i), vecs[i]);
      end

      // Reset asserted after two of four writes abandons the job at once.
      apply_stimulus("rst_job_start", mk(1, 'h700, 4, '0,       0, 1,  0, 'h604, dw('h84), 1, 0, 0));
      apply_stimulus("rst_job_w0",    mk(0, 0,     0, dw('h90), 1, 1,  0, 'h604, dw('h84), 1, 0, 0));
      apply_stimulus("rst_job_w1",    mk(0, 0,     0, dw('h91), 1, 1,  1, 'h700, dw('h90), 1, 0, 0));
      apply_stimulus("rst_job_w2",    mk(0, 0,     0, dw('h92), 1, 1,  1, 'h701, dw('h91), 1, 0, 0));
      rst            = 1'b0;
      xpe_data       = dw('h93);
      xpe_data_valid = 1'b1;
      #1;
      check_output("rst_async_clear", 0, '0, '0, 0, 0, 2'b00);
      apply_stimulus("rst_held_0", mk(1, 'h7FF, 2, dw('h93), 1, 1,  0, '0, '0, 0, 0, 0));
      apply_stimulus("rst_held_1", mk(0, 0,     0, dw('h94), 1, 1,  0, '0, '0, 0, 0, 0));
      rst = 1'b1;
      apply_stimulus("post_rst_start", mk(1, 'h7A0, 1, '0,       0, 1,  0, '0,     '0,       1, 0, 0));
      apply_stimulus("post_rst_word",  mk(0, 0,     0, dw('hA5), 1, 1,  0, '0,     '0,       1, 0, 0));
      apply_stimulus("post_rst_write", mk(0, 0,     0, '0,       0, 1,  1, 'h7A0, dw('hA5), 1, 0, 0));
      apply_stimulus("post_rst_done",  mk(0, 0,     0, '0,       0, 1,  0, 'h7A0, dw('hA5), 1, 1, 0));
      apply_stimulus("post_rst_idle",  mk(0, 0,     0, '0,       0, 1,  0, 'h7A0, dw('hA5), 0, 0, 0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
